btn_load_ctrl: RTL and testbench

- Upstream stage that produces the `in`/`en` pair for the lab's 4-bit enabled load register.
- Synchronises a raw push-button and 4 slide switches, then debounces the button.
- On each accepted press, emits the switch value with a single-cycle load-enable pulse.
- Also drives a debounced "pressed" level for LEDs.

---
 rtl/lab5_pkg.sv | 21 ++
 rtl/btn_load_ctrl_if.sv | 13 +
 rtl/sync_2ff.sv | 26 ++
 rtl/btn_load_ctrl.sv | 98 +++++++++
 tb/tb_btn_load_ctrl.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/lab5_pkg.sv
// Shared definitions for the lab's debounced inputs.
//   - state encodings for the press/release debounce FSM
//   - default debounce window (10 ms at 100 MHz) and counter width
package lab5_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam int DEF_CNT_MAX = 1000000;
  localparam int DEF_CNT_W   = 20;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    PRESS_WAIT   = ST_PRESS_WAIT,
    HELD         = ST_HELD,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } state_e;

endpackage

// File: rtl/btn_load_ctrl_if.sv
// Button/switch inputs and load-register outputs of btn_load_ctrl.
//   slave  : the controller (consumes btn/sw, drives data_o/en_o/pressed_o)
//   master : the environment (drives btn/sw, observes outputs)
interface btn_load_ctrl_if;
  logic       btn;
  logic [3:0] sw;
  logic [3:0] data_o;
  logic       en_o;
  logic       pressed_o;

  modport slave  (input  btn, sw, output data_o, en_o, pressed_o);
  modport master (output btn, sw, input  data_o, en_o, pressed_o);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
//   clk, rst_n : clock, async active-low reset (clears both stages)
//   d          : asynchronous input, W bits
//   q          : synchronised output, 2 cycles latency
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_load_ctrl.sv
// Front end for the 4-bit enabled load register: synchronises the raw
// button and switches, debounces the button, and on each accepted press
// emits the switch value together with a one-cycle load pulse.
//   clk, rst_n     : clock, async active-low reset
//   bus.btn        : raw push-button (active-high, bouncing)
//   bus.sw         : raw slide switches
//   bus.data_o     : switch value captured at the last accepted press
//   bus.en_o       : one-cycle load pulse
//   bus.pressed_o  : debounced button level
module btn_load_ctrl
  import lab5_pkg::*;
#(
  parameter int         CNT_MAX = DEF_CNT_MAX,
  parameter int         CNT_W   = DEF_CNT_W,
  parameter logic [3:0] D_INIT  = 4'b0000
) (
  input  logic               clk,
  input  logic               rst_n,
  btn_load_ctrl_if.slave     bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic       btn_s;
  logic [3:0] sw_s;

  sync_2ff #(.W(1)) u_sync_btn (.clk(clk), .rst_n(rst_n), .d(bus.btn), .q(btn_s));
  sync_2ff #(.W(4)) u_sync_sw  (.clk(clk), .rst_n(rst_n), .d(bus.sw),  .q(sw_s));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             pressed_q, pressed_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= D_INIT;
      en_q      <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      en_q      <= en_d;
      pressed_q <= pressed_d;
    end
  end

  // Counter is zeroed on every state change, so it only ever counts
  // consecutive stable cycles within one WAIT state and cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    data_d  = data_q;
    en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          en_d    = 1'b1;
          data_d  = sw_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        // A release bounce drops back to HELD without a new pulse.
        if (btn_s) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pressed_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  assign bus.data_o    = data_q;
  assign bus.en_o      = en_q;
  assign bus.pressed_o = pressed_q;

endmodule

// File: tb/tb_btn_load_ctrl.sv
// Directed bench for btn_load_ctrl with CNT_MAX=4, CNT_W=3, D_INIT=4'hA.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_btn_load_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   passes = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  btn_load_ctrl_if bus ();

  btn_load_ctrl #(.CNT_MAX(4), .CNT_W(3), .D_INIT(4'hA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Press with btn high from now; en pulse expected after the 7th edge.
  task automatic clean_press(input string tag, input logic [3:0] swv, input logic [3:0] dprev);
    bus.sw  = swv;
    bus.btn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk({tag, "_en"},      4'(bus.en_o),      4'(k == 7));
      chk({tag, "_pressed"}, 4'(bus.pressed_o), 4'(k == 7));
      chk({tag, "_data"},    bus.data_o,        (k == 7) ? swv : dprev);
    end
  endtask

  task automatic release_idle(input logic [3:0] dexp);
    bus.btn = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    chk("rel_pressed", 4'(bus.pressed_o), 4'h0);
    chk("rel_data",    bus.data_o,        dexp);
  endtask

  initial begin
    // Reset with a toggling button.
    rst_n   = 1'b0;
    bus.btn = 1'b0;
    bus.sw  = 4'h5;
    #1;
    for (int k = 0; k < 6; k++) begin
      bus.btn = ~bus.btn;
      tick();
      chk("rst_data",    bus.data_o,        4'hA);
      chk("rst_en",      4'(bus.en_o),      4'h0);
      chk("rst_pressed", 4'(bus.pressed_o), 4'h0);
    end
    bus.btn = 1'b0;
    rst_n   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("post_rst_data",    bus.data_o,        4'hA);
      chk("post_rst_en",      4'(bus.en_o),      4'h0);
      chk("post_rst_pressed", 4'(bus.pressed_o), 4'h0);
    end

    // Bounce rejection: 3 high / 1 low, five times.
    bus.sw = 4'hF;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        bus.btn = (k < 3);
        tick();
        chk("bounce_en",      4'(bus.en_o),      4'h0);
        chk("bounce_pressed", 4'(bus.pressed_o), 4'h0);
      end
    end
    bus.btn = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("bounce_tail_en", 4'(bus.en_o), 4'h0);
    end
    chk("bounce_data", bus.data_o, 4'hA);

    // Clean press, then hold 20 cycles with no repeat.
    clean_press("press1", 4'h3, 4'hA);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("hold_en",      4'(bus.en_o),      4'h0);
      chk("hold_pressed", 4'(bus.pressed_o), 4'h1);
      chk("hold_data",    bus.data_o,        4'h3);
    end

    // Release bounce: low 2, high 1, low for good.
    for (int k = 1; k <= 10; k++) begin
      bus.btn = (k == 3);
      if (k > 3) bus.btn = 1'b0;
      tick();
      chk("relb_en",      4'(bus.en_o),      4'h0);
      chk("relb_pressed", 4'(bus.pressed_o), 4'(k < 10));
    end
    bus.btn = 1'b0;
    tick();
    clean_press("press2", 4'hC, 4'h3);
    release_idle(4'hC);

    // Reset in PRESS_WAIT with cnt=2 (5 edges after btn rises).
    bus.sw  = 4'h7;
    bus.btn = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rst_n   = 1'b0;
    bus.btn = 1'b0;
    #1;
    chk("midrst_data", bus.data_o,   4'hA);
    chk("midrst_en",   4'(bus.en_o), 4'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("midrst_after_en", 4'(bus.en_o), 4'h0);
    end
    chk("midrst_after_data", bus.data_o, 4'hA);
    clean_press("press3", 4'h6, 4'hA);

    // Switches change while held: data must not move.
    bus.sw = 4'h1;
    for (int k = 0; k < 5; k++) tick();
    bus.sw = 4'h9;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("swheld_data", bus.data_o,   4'h6);
      chk("swheld_en",   4'(bus.en_o), 4'h0);
    end
    release_idle(4'h6);
    clean_press("press4", 4'h9, 4'h6);
    tick();
    chk("press4_en_clear", 4'(bus.en_o), 4'h0);
    chk("press4_data_hold", bus.data_o,  4'h9);

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule
